seq_fsm_pattern_det: RTL and testbench
======================================

SEQ_FSM_PATTERN_DET -- requirements
Module: seq_fsm_pattern_det

Interface
REQ-001 The block SHALL take parameter N, default 3, meaning pattern length, legal range 2..8.
REQ-002 The block SHALL take parameter PATTERN [N-1:0], default 3'b101, meaning the target bit sequence, where PATTERN[N-1] is the first bit expected.
REQ-003 The block SHALL take parameter OVERLAP, default 1, meaning 1 = overlapping matches and 0 = restart after each match.
REQ-004 The block SHALL take parameter CW, default 8, meaning match-counter width.
REQ-005 Ports SHALL be: clk, input, 1 bit, clock; reset, input, 1 bit, one clock, reset synchronous and active-high.
REQ-006 Ports SHALL include: en, input, 1 bit, input-valid qualifier; in_, input, 1 bit, serial data bit.
REQ-007 Ports SHALL include: state, output, SW = $clog2(N+1) bits, current state equal to the number of pattern bits matched.
REQ-008 Ports SHALL include: out, output, 1 bit, Moore match flag; count, output, CW bits, match counter.

Function
REQ-009 State k (0..N) SHALL mean the last k accepted bits equal PATTERN[N-1 -: k].
REQ-010 On a clk edge with en=1 and state<N, next state SHALL be the longest j<=N such that (matched prefix followed by in_) ends with PATTERN[N-1 -: j].
REQ-011 From state N with OVERLAP=1, next state SHALL be computed per REQ-010 using the full pattern as the matched prefix.
REQ-012 From state N with OVERLAP=0, next state SHALL equal the transition taken from state 0 on in_.
REQ-013 With en=0, state and count SHALL hold, and in_ SHALL be ignored.
REQ-014 out SHALL be 1 iff state==N, as a purely Moore output with no combinational path from in_ or en.
REQ-015 count SHALL increment by 1 on each edge where en=1 and next state==N.
REQ-016 count SHALL saturate at 2^CW-1 and never wrap.
REQ-017 Next-state logic SHALL be derived at elaboration from PATTERN and N, with no hand-coded per-pattern tables.
REQ-018 With N=3, PATTERN=101, OVERLAP=1, the block SHALL be cycle-exact with the existing 4-state, 1-input, 1-output Moore FSM: states A/B/C/D map to 0/1/2/3, and out=1 in D.

Reset
REQ-019 While reset=1 at a clk edge, state SHALL become 0, out 0 and count 0, regardless of en and in_.
REQ-020 Reset SHALL take priority over en in the same cycle.
REQ-021 A reset asserted mid-pattern SHALL discard partial matches, and the first post-reset bit SHALL be evaluated from state 0.

Configuration
REQ-022 Macro SEQ_FSM_PATTERN_DET_COUNT_EN SHALL compile the match counter in.
REQ-023 Defined: count SHALL behave per REQ-015/016.
REQ-024 Undefined: the count port SHALL remain present, be driven constant 0, and contain no counter flops.

Structure
REQ-025 Package seq_fsm_pkg SHALL hold the state-width helper function, N range constants, and a function computing the prefix-suffix (failure) next state.
REQ-026 The saturating counter SHALL be a sub-module, seq_fsm_sat_counter, parameterised by CW, with ports clk, reset, inc and count.
REQ-027 The FSM state register and out decode SHALL reside in seq_fsm_pattern_det.

Verification
REQ-028 Baseline scenario: N=3, PATTERN=101, OVERLAP=1, en=1, in_ = 0,1,1,0,0,1,0,1,0,1,0,0,0 -> state = 0,1,1,2,0,1,2,3,2,3,2,0,0, out high exactly twice, final count=2.
REQ-029 Non-overlap scenario: same pattern, OVERLAP=0, in_ = 1,0,1,0,1 -> state = 1,2,3,0,1 and count=1.
REQ-030 Overlap comparison scenario: same stimulus with OVERLAP=1 -> state = 1,2,3,2,3 and count=2.
REQ-031 Enable-gating scenario: reach state 2 on 1,0, then hold en=0 for 3 cycles with in_ toggling -> state stays 2; then en=1, in_=1 -> state=3, out=1.
REQ-032 Reset mid-pattern scenario: in state 2, assert reset with in_=1 -> state=0, count=0; then in_=0 -> state=0.
REQ-033 Saturation scenario: CW=2, N=4, PATTERN=1100, six non-overlapping occurrences -> count stops at 3; with the macro undefined, count=0 throughout.

Source files
------------

// File: rtl/seq_fsm_pkg.sv
// -----------------------------------------------------------------------------
// seq_fsm_pkg
// Shared helpers for the serial pattern detector:
//   - N_MIN / N_MAX   : legal range of the pattern length N
//   - state_width()   : bits needed to hold a state value 0..N
//   - next_state()    : prefix-suffix (failure) transition, evaluated at
//                       elaboration to build the detector's transition table
// -----------------------------------------------------------------------------
package seq_fsm_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 8;

  // A state counts matched pattern bits, so it ranges over 0..n inclusive.
  function automatic int state_width(input int n);
    return $clog2(n + 1);
  endfunction

  // pat holds the pattern right-aligned in pat[n-1:0], pat[n-1] is sent first.
  // k is the number of bits currently matched, b is the incoming bit.
  // Returns the longest j <= n such that the sequence
  //   pat[n-1 -: k] followed by b
  // ends with the pattern prefix pat[n-1 -: j].
  function automatic int next_state(input logic [7:0] pat, input int n,
                                    input int k, input logic b);
    logic [8:0] s;    // s[0] is the newest bit, s[k] the oldest matched bit
    int         best;
    int         jmax;
    logic       ok;
    s    = '0;
    s[0] = b;
    for (int m = 1; m <= k; m++) begin
      s[m] = pat[n - k - 1 + m];
    end
    jmax = (k + 1 < n) ? k + 1 : n;
    best = 0;
    for (int j = 1; j <= jmax; j++) begin
      ok = 1'b1;
      // Prefix of length j aligned so its last bit sits against s[0].
      for (int i = 0; i < j; i++) begin
        if (s[i] != pat[n - j + i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_fsm_sat_counter.sv
// -----------------------------------------------------------------------------
// seq_fsm_sat_counter
// Saturating up-counter: counts inc pulses and sticks at 2^CW-1.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high clear
//   inc    in   add one this edge (ignored once saturated)
//   count  out  CW-bit count value
// -----------------------------------------------------------------------------
module seq_fsm_sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_fsm_pattern_det.sv
// -----------------------------------------------------------------------------
// seq_fsm_pattern_det
// Moore serial pattern detector. State k means the last k accepted bits equal
// the first k pattern bits; out is high while the whole pattern is matched.
//
// Parameters:
//   N        pattern length (2..8)
//   PATTERN  target sequence, PATTERN[N-1] is the first bit expected
//   OVERLAP  1 = overlapping matches, 0 = restart from idle after a match
//   CW       match-counter width
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high; clears state and count
//   en     in   accept in_ on this edge; state and count hold when low
//   in_    in   serial data bit
//   state  out  number of pattern bits currently matched (0..N)
//   out    out  registered match flag (state == N)
//   count  out  saturating number of matches
// Handshake: a bit is consumed on every rising clk edge where en is high;
// there is no back-pressure, the block always accepts.
//
// Build option: define SEQ_FSM_PATTERN_DET_COUNT_EN to include the match
// counter; without it count is tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module seq_fsm_pattern_det
  import seq_fsm_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_,
  output logic [state_width(N)-1:0] state,
  output logic                      out,
  output logic [CW-1:0]             count
);

  localparam int             SW      = state_width(N);
  localparam int             NSTATE  = 2 ** SW;
  localparam logic [SW-1:0]  ST_FULL = SW'(N);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
    $error("seq_fsm_pattern_det: N out of range");
  end

  // Transition table indexed by current state, one array per input value.
  // Encodings above N cannot be reached; they fall back to idle.
  logic [SW-1:0] w_tbl0 [0:NSTATE-1];
  logic [SW-1:0] w_tbl1 [0:NSTATE-1];

  for (genvar k = 0; k < NSTATE; k++) begin : g_tbl
    if (k <= N) begin : g_live
      // Without overlap a full match behaves like idle for the next bit.
      localparam int KS = ((k == N) && (OVERLAP == 1'b0)) ? 0 : k;
      localparam logic [SW-1:0] NXT0 = SW'(next_state(8'(PATTERN), N, KS, 1'b0));
      localparam logic [SW-1:0] NXT1 = SW'(next_state(8'(PATTERN), N, KS, 1'b1));
      assign w_tbl0[k] = NXT0;
      assign w_tbl1[k] = NXT1;
    end else begin : g_dead
      assign w_tbl0[k] = '0;
      assign w_tbl1[k] = '0;
    end
  end

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (en) begin
      w_next = in_ ? w_tbl1[r_state] : w_tbl0[r_state];
    end
  end

  // out decodes the registered state only, so it has no path from in_/en.
  assign state = r_state;
  assign out   = (r_state == ST_FULL);

`ifdef SEQ_FSM_PATTERN_DET_COUNT_EN
  logic w_inc;
  assign w_inc = en && (w_next == ST_FULL);

  seq_fsm_sat_counter #(
    .CW (CW)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .count (count)
  );
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_fsm_pattern_det.sv
// -----------------------------------------------------------------------------
// tb_seq_fsm_pattern_det
// Four detector instances share clk/reset/en/in_:
//   0: N=3 101   overlap  CW=8      1: N=3 101   no-overlap CW=8
//   2: N=4 1100  no-overlap CW=2    3: N=5 11011 overlap    CW=3
// The reference model keeps the accepted-bit history and looks for the
// longest pattern prefix that ends the history.
// -----------------------------------------------------------------------------
module tb_seq_fsm_pattern_det;

`ifdef SEQ_FSM_PATTERN_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int P_N   [4] = '{3, 3, 4, 5};
  localparam int P_PAT [4] = '{5, 5, 12, 27};
  localparam int P_OV  [4] = '{1, 0, 0, 1};
  localparam int P_CW  [4] = '{8, 8, 2, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, en, in_;
  always #5 clk = ~clk;

  logic [1:0] st_a, st_b;
  logic [2:0] st_c, st_d;
  logic       out_a, out_b, out_c, out_d;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] cnt_d;

  seq_fsm_pattern_det #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CW(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .in_(in_), .state(st_a), .out(out_a), .count(cnt_a));
  seq_fsm_pattern_det #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CW(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .in_(in_), .state(st_b), .out(out_b), .count(cnt_b));
  seq_fsm_pattern_det #(.N(4), .PATTERN(4'b1100), .OVERLAP(1'b0), .CW(2)) u_c (
    .clk(clk), .reset(reset), .en(en), .in_(in_), .state(st_c), .out(out_c), .count(cnt_c));
  seq_fsm_pattern_det #(.N(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CW(3)) u_d (
    .clk(clk), .reset(reset), .en(en), .in_(in_), .state(st_d), .out(out_d), .count(cnt_d));

  logic [7:0] o_st  [4];
  logic [7:0] o_cnt [4];
  logic       o_out [4];
  assign o_st[0] = 8'(st_a);  assign o_st[1] = 8'(st_b);
  assign o_st[2] = 8'(st_c);  assign o_st[3] = 8'(st_d);
  assign o_cnt[0] = cnt_a;    assign o_cnt[1] = cnt_b;
  assign o_cnt[2] = 8'(cnt_c); assign o_cnt[3] = 8'(cnt_d);
  assign o_out[0] = out_a;    assign o_out[1] = out_b;
  assign o_out[2] = out_c;    assign o_out[3] = out_d;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int m_hist [4];
  int m_len  [4];
  int m_st   [4];
  int m_cnt  [4];

  task automatic model_step(input logic r, input logic e, input logic b);
    int n, best;
    for (int d = 0; d < 4; d++) begin
      n = P_N[d];
      if (r) begin
        m_hist[d] = 0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0;
      end else if (e) begin
        if ((m_st[d] == n) && (P_OV[d] == 0)) m_len[d] = 0;
        m_hist[d] = ((m_hist[d] << 1) | int'(b)) & 16'hffff;
        m_len[d]  = (m_len[d] < 16) ? m_len[d] + 1 : 16;
        best = 0;
        for (int j = 1; j <= n; j++) begin
          if ((j <= m_len[d]) &&
              ((m_hist[d] & ((1 << j) - 1)) == (P_PAT[d] >> (n - j)))) best = j;
        end
        m_st[d] = best;
        if ((best == n) && (m_cnt[d] < (1 << P_CW[d]) - 1)) m_cnt[d]++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic e, input logic b);
    reset = r; en = e; in_ = b;
    @(posedge clk);
    #1;
    model_step(r, e, b);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (o_st[d] !== 8'd0) begin n_err++; $display("FAIL reset_state dut%0d got %0d want 0", d, o_st[d]); end
      n_cmp++; if (o_out[d] !== 1'b0) begin n_err++; $display("FAIL reset_out dut%0d got %b want 0", d, o_out[d]); end
      n_cmp++; if (o_cnt[d] !== 8'd0) begin n_err++; $display("FAIL reset_count dut%0d got %0d want 0", d, o_cnt[d]); end
    end
  endtask

  task automatic test_baseline();
    int seq [13];
    int exp [13];
    int highs;
    seq = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    exp = '{0, 1, 1, 2, 0, 1, 2, 3, 2, 3, 2, 0, 0};
    highs = 0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b1, 1'(seq[i]));
      n_cmp++; if (o_st[0] !== 8'(exp[i])) begin n_err++; $display("FAIL baseline_state step%0d got %0d want %0d", i, o_st[0], exp[i]); end
      n_cmp++; if (o_out[0] !== (exp[i] == 3)) begin n_err++; $display("FAIL baseline_out step%0d got %b want %b", i, o_out[0], exp[i] == 3); end
      if (o_out[0] === 1'b1) highs++;
    end
    n_cmp++; if (highs != 2) begin n_err++; $display("FAIL baseline_out_highs got %0d want 2", highs); end
    n_cmp++; if (o_cnt[0] !== (CNT_ON ? 8'd2 : 8'd0)) begin n_err++; $display("FAIL baseline_count got %0d want %0d", o_cnt[0], CNT_ON ? 2 : 0); end
  endtask

  task automatic test_overlap_modes();
    int seq [5];
    int exp_ov [5];
    int exp_no [5];
    seq    = '{1, 0, 1, 0, 1};
    exp_ov = '{1, 2, 3, 2, 3};
    exp_no = '{1, 2, 3, 0, 1};
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'(seq[i]));
      n_cmp++; if (o_st[0] !== 8'(exp_ov[i])) begin n_err++; $display("FAIL overlap_state step%0d got %0d want %0d", i, o_st[0], exp_ov[i]); end
      n_cmp++; if (o_st[1] !== 8'(exp_no[i])) begin n_err++; $display("FAIL nonoverlap_state step%0d got %0d want %0d", i, o_st[1], exp_no[i]); end
    end
    n_cmp++; if (o_cnt[0] !== (CNT_ON ? 8'd2 : 8'd0)) begin n_err++; $display("FAIL overlap_count got %0d want %0d", o_cnt[0], CNT_ON ? 2 : 0); end
    n_cmp++; if (o_cnt[1] !== (CNT_ON ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL nonoverlap_count got %0d want %0d", o_cnt[1], CNT_ON ? 1 : 0); end
  endtask

  task automatic test_enable_gating();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_st[0] !== 8'd2) begin n_err++; $display("FAIL gate_pre_state got %0d want 2", o_st[0]); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'(i % 2 == 0));
      n_cmp++; if (o_st[0] !== 8'd2) begin n_err++; $display("FAIL gate_hold_state cyc%0d got %0d want 2", i, o_st[0]); end
      n_cmp++; if (o_cnt[0] !== 8'd0) begin n_err++; $display("FAIL gate_hold_count cyc%0d got %0d want 0", i, o_cnt[0]); end
    end
    cycle(1'b0, 1'b1, 1'b1);
    n_cmp++; if (o_st[0] !== 8'd3) begin n_err++; $display("FAIL gate_post_state got %0d want 3", o_st[0]); end
    n_cmp++; if (o_out[0] !== 1'b1) begin n_err++; $display("FAIL gate_post_out got %b want 1", o_out[0]); end
    n_cmp++; if (o_cnt[0] !== (CNT_ON ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL gate_post_count got %0d want %0d", o_cnt[0], CNT_ON ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_st[0] !== 8'd2) begin n_err++; $display("FAIL rstmid_pre_state got %0d want 2", o_st[0]); end
    cycle(1'b1, 1'b1, 1'b1);
    n_cmp++; if (o_st[0] !== 8'd0) begin n_err++; $display("FAIL rstmid_state got %0d want 0", o_st[0]); end
    n_cmp++; if (o_cnt[0] !== 8'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", o_cnt[0]); end
    n_cmp++; if (o_out[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_out got %b want 0", o_out[0]); end
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_st[0] !== 8'd0) begin n_err++; $display("FAIL rstmid_first_bit got %0d want 0", o_st[0]); end
  endtask

  task automatic test_saturation();
    int pat [4];
    int want;
    pat = '{1, 1, 0, 0};
    cycle(1'b1, 1'b0, 1'b0);
    for (int occ = 1; occ <= 6; occ++) begin
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'(pat[i]));
      want = CNT_ON ? ((occ < 3) ? occ : 3) : 0;
      n_cmp++; if (o_st[2] !== 8'd4) begin n_err++; $display("FAIL sat_state occ%0d got %0d want 4", occ, o_st[2]); end
      n_cmp++; if (o_cnt[2] !== 8'(want)) begin n_err++; $display("FAIL sat_count occ%0d got %0d want %0d", occ, o_cnt[2], want); end
    end
  endtask

  task automatic test_random();
    logic r, e, b;
    int   want_cnt;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      cycle(r, e, b);
      for (int d = 0; d < 4; d++) begin
        want_cnt = CNT_ON ? m_cnt[d] : 0;
        n_cmp++; if (o_st[d] !== 8'(m_st[d])) begin n_err++; $display("FAIL rand_state dut%0d cyc%0d got %0d want %0d", d, i, o_st[d], m_st[d]); end
        n_cmp++; if (o_out[d] !== (m_st[d] == P_N[d])) begin n_err++; $display("FAIL rand_out dut%0d cyc%0d got %b want %b", d, i, o_out[d], m_st[d] == P_N[d]); end
        n_cmp++; if (o_cnt[d] !== 8'(want_cnt)) begin n_err++; $display("FAIL rand_count dut%0d cyc%0d got %0d want %0d", d, i, o_cnt[d], want_cnt); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; en = 1'b0; in_ = 1'b0;
    for (int d = 0; d < 4; d++) begin
      m_hist[d] = 0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0;
    end
    test_reset();
    test_baseline();
    test_overlap_modes();
    test_enable_gating();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
